// File: rtl/fpu_exec_pkg.sv
// Shared opcode, unit-map, state and status definitions for the FPU execution sequencer.
// Also provides the canonical quiet-NaN pattern used for timed-out operations.
package fpu_exec_pkg;

    localparam logic [5:0] OP_ABS     = 6'd54;
    localparam logic [5:0] OP_NEG     = 6'd55;
    localparam logic [5:0] OP_ADD     = 6'd56;
    localparam logic [5:0] OP_SUB     = 6'd57;
    localparam logic [5:0] OP_MUL     = 6'd58;
    localparam logic [5:0] OP_DIV     = 6'd59;
    localparam logic [5:0] OP_CVT_S_W = 6'd60;
    localparam logic [5:0] OP_CVT_W_S = 6'd61;
    localparam logic [5:0] OP_MOV     = 6'd62;
    localparam logic [5:0] OP_SQRT    = 6'd63;

    localparam int unsigned UNIT_IDX_W = 3;
    localparam logic [UNIT_IDX_W-1:0] UNIT_ADDSUB  = 3'd0;
    localparam logic [UNIT_IDX_W-1:0] UNIT_MUL     = 3'd1;
    localparam logic [UNIT_IDX_W-1:0] UNIT_DIV     = 3'd2;
    localparam logic [UNIT_IDX_W-1:0] UNIT_CVT_S_W = 3'd3;
    localparam logic [UNIT_IDX_W-1:0] UNIT_CVT_W_S = 3'd4;
    localparam logic [UNIT_IDX_W-1:0] UNIT_SQRT    = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT,
        ST_DONE
    } state_t;

    localparam logic [1:0] STATUS_OK      = 2'b00;
    localparam logic [1:0] STATUS_ILLEGAL = 2'b01;
    localparam logic [1:0] STATUS_TIMEOUT = 2'b10;

    // Sign 0, exponent all ones, mantissa MSB set; callers take the low `width` bits.
    function automatic logic [63:0] qnan(input int unsigned width);
        return (width == 64) ? 64'h7FF8_0000_0000_0000 : 64'h0000_0000_7FC0_0000;
    endfunction

endpackage

// File: rtl/fpu_exec_sequencer_inline.sv
// Combinational decode: inline ABS/NEG/MOV result, illegal-opcode flag and
// external operator unit selection for unit-dispatched opcodes.
module fpu_inline_op
    import fpu_exec_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [5:0]            inst,
    input  logic [WIDTH-1:0]      fs,
    output logic [WIDTH-1:0]      result,
    output logic                  is_unit_op,
    output logic                  is_illegal,
    output logic [UNIT_IDX_W-1:0] unit_index
);

    always_comb begin
        result     = '0;
        is_unit_op = 1'b0;
        is_illegal = 1'b0;
        unit_index = UNIT_ADDSUB;
        case (inst)
            OP_ABS:         result = {1'b0, fs[WIDTH-2:0]};
            OP_NEG:         result = {~fs[WIDTH-1], fs[WIDTH-2:0]};
            OP_MOV:         result = fs;
            OP_ADD, OP_SUB: is_unit_op = 1'b1;
            OP_MUL: begin
                is_unit_op = 1'b1;
                unit_index = UNIT_MUL;
            end
            OP_DIV: begin
                is_unit_op = 1'b1;
                unit_index = UNIT_DIV;
            end
            OP_CVT_S_W: begin
                is_unit_op = 1'b1;
                unit_index = UNIT_CVT_S_W;
            end
            OP_CVT_W_S: begin
                is_unit_op = 1'b1;
                unit_index = UNIT_CVT_W_S;
            end
            OP_SQRT: begin
                is_unit_op = 1'b1;
                unit_index = UNIT_SQRT;
            end
            default:        is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/fpu_exec_sequencer.sv
// Single-issue FPU execution sequencer: inline ABS/NEG/MOV, dispatch of other ops to
// external operator units, with timeout, flush and stale-response suppression.
module fpu_exec_sequencer
    import fpu_exec_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned TAG_W     = 4,
    parameter int unsigned NUM_UNITS = 6,
    parameter int unsigned TIMEOUT   = 64
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       issue_valid,
    output logic                       issue_ready,
    input  logic [5:0]                 issue_inst,
    input  logic [TAG_W-1:0]           issue_tag,
    input  logic [WIDTH-1:0]           issue_fs,
    input  logic [WIDTH-1:0]           issue_ft,
    input  logic                       flush,
    output logic [NUM_UNITS-1:0]       unit_req_valid,
    output logic [7:0]                 unit_op,
    output logic [WIDTH-1:0]           unit_a,
    output logic [WIDTH-1:0]           unit_b,
    input  logic [NUM_UNITS-1:0]       unit_resp_valid,
    input  logic [NUM_UNITS*WIDTH-1:0] unit_resp_data,
    output logic                       result_valid,
    input  logic                       result_ready,
    output logic [WIDTH-1:0]           result_data,
    output logic [TAG_W-1:0]           result_tag,
    output logic [1:0]                 result_status
);

    localparam int unsigned CNT_W  = $clog2(TIMEOUT + 1);
    localparam logic [63:0] QNAN64 = qnan(WIDTH);

    state_t                  state, state_nxt;
    logic [NUM_UNITS-1:0]    stale, stale_nxt;
    logic [CNT_W-1:0]        wait_cnt;
    logic [UNIT_IDX_W-1:0]   cur_unit;
    logic [NUM_UNITS-1:0]    cur_onehot;
    logic [WIDTH-1:0]        resp_slice;
    logic [WIDTH-1:0]        inl_result;
    logic                    inl_is_unit, inl_illegal;
    logic [UNIT_IDX_W-1:0]   inl_unit;
    logic                    accept, cur_resp, timed_out;

    fpu_inline_op #(.WIDTH(WIDTH)) u_inline (
        .inst       (issue_inst),
        .fs         (issue_fs),
        .result     (inl_result),
        .is_unit_op (inl_is_unit),
        .is_illegal (inl_illegal),
        .unit_index (inl_unit)
    );

    assign cur_onehot     = NUM_UNITS'(1) << cur_unit;
    assign issue_ready    = reset_n && (state == ST_IDLE) && !flush;
    assign accept         = issue_valid && issue_ready;
    assign result_valid   = (state == ST_DONE);
    assign unit_req_valid = ((state == ST_SEND) && !flush) ? cur_onehot : '0;
    assign cur_resp       = |(unit_resp_valid & cur_onehot & ~stale);
    assign timed_out      = (wait_cnt == CNT_W'(TIMEOUT - 1));

    always_comb begin
        resp_slice = '0;
        for (int unsigned u = 0; u < NUM_UNITS; u++) begin
            if (cur_unit == UNIT_IDX_W'(u)) resp_slice = unit_resp_data[u*WIDTH +: WIDTH];
        end
    end

    // A pending unit becomes stale only if its real answer has not arrived this cycle;
    // a stale answer landing in the same cycle still leaves the real one outstanding.
    always_comb begin
        stale_nxt = stale & ~unit_resp_valid;
        if ((state == ST_WAIT) && (flush || timed_out) && !cur_resp) begin
            stale_nxt = stale_nxt | cur_onehot;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) state_nxt = inl_is_unit ? ST_SEND : ST_DONE;
            ST_SEND: state_nxt = flush ? ST_IDLE : ST_WAIT;
            ST_WAIT: begin
                if (flush)                       state_nxt = ST_IDLE;
                else if (cur_resp || timed_out)  state_nxt = ST_DONE;
            end
            ST_DONE: if (flush || result_ready) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stale         <= '0;
            wait_cnt      <= '0;
            cur_unit      <= '0;
            unit_op       <= '0;
            unit_a        <= '0;
            unit_b        <= '0;
            result_data   <= '0;
            result_tag    <= '0;
            result_status <= '0;
        end else begin
            stale    <= stale_nxt;
            wait_cnt <= (state == ST_WAIT) ? wait_cnt + CNT_W'(1) : '0;
            if (accept) begin
                unit_a        <= issue_fs;
                unit_b        <= issue_ft;
                unit_op       <= {7'b0, issue_inst == OP_SUB};
                cur_unit      <= inl_unit;
                result_tag    <= issue_tag;
                result_data   <= inl_result;
                result_status <= inl_illegal ? STATUS_ILLEGAL : STATUS_OK;
            end
            if ((state == ST_WAIT) && !flush) begin
                if (cur_resp) begin
                    result_data   <= resp_slice;
                    result_status <= STATUS_OK;
                end else if (timed_out) begin
                    result_data   <= QNAN64[WIDTH-1:0];
                    result_status <= STATUS_TIMEOUT;
                end
            end
        end
    end

endmodule
